cont_fecha: RTL and testbench

Parametrised date-field counter, successor to the single-field month counter. It holds day, month and year as one coherent date, and each field can be edited from the PS/2 keypad through the shared position and edit-mode controls. It also advances automatically on a day-rollover pulse from the time-of-day counters, applying month length and leap-year rules. BCD outputs feed the RTC write path and the VGA date display directly.

---
 rtl/fecha_pkg.sv | 21 ++
 rtl/bin2bcd_99.sv | 19 +
 rtl/cont_fecha.sv | 120 ++++++++++++
 tb/tb_cont_fecha.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fecha_pkg.sv
// Shared definitions for the date counter: default key codes, field positions
// and the month-length function with the leap-year rule.
package fecha_pkg;

    localparam logic [7:0] KEY_UP_DEF   = 8'h75;
    localparam logic [7:0] KEY_DOWN_DEF = 8'h72;

    localparam logic [1:0] POS_DIA  = 2'd0;
    localparam logic [1:0] POS_MES  = 2'd1;
    localparam logic [1:0] POS_ANIO = 2'd2;

    // Years 00..99 map to 2000..2099, so every multiple of 4 is a leap year.
    function automatic logic [4:0] dias_mes(input logic [3:0] mes, input logic [6:0] anio);
        case (mes)
            4'd2:                      return (anio[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_99.sv
// Combinational binary (0..99) to two-digit BCD converter.
module bin2bcd_99 (
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [3:0] ones;

    always_comb begin
        tens = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (bin >= 7'(10 * i)) tens = 4'(i);
        end
        ones = 4'(bin - 7'(10 * tens));
        bcd  = {tens, ones};
    end

endmodule

// File: rtl/cont_fecha.sv
// Day/month/year counter, editable from the keypad and auto-advanced on the
// day-rollover pulse; BCD outputs drive the RTC write path and the display.
module cont_fecha
    import fecha_pkg::*;
#(
    parameter int unsigned    N        = 8,
    parameter int unsigned    P        = 2,
    parameter logic [N-1:0]   KEY_UP   = N'(KEY_UP_DEF),
    parameter logic [N-1:0]   KEY_DOWN = N'(KEY_DOWN_DEF),
    parameter int unsigned    ANIO_MAX = 99
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [P-1:0] posicion,
    input  logic         f2,
    input  logic         en_codigo,
    input  logic [N-1:0] key_code,
    input  logic         inc_dia,
    output logic [N-1:0] dato_dia,
    output logic [N-1:0] dato_mes,
    output logic [N-1:0] dato_anio,
    output logic         carry_anio
);

    localparam logic [6:0] AnioMax = 7'(ANIO_MAX);

    logic [4:0] dia_q, dia_d;
    logic [3:0] mes_q, mes_d;
    logic [6:0] anio_q, anio_d;
    logic       carry_q, carry_d;
    logic [4:0] lim, lim_new;
    logic       key_up, key_dn;
    logic [7:0] bcd_dia, bcd_mes, bcd_anio;

    always_comb begin
        dia_d   = dia_q;
        mes_d   = mes_q;
        anio_d  = anio_q;
        carry_d = 1'b0;
        lim     = dias_mes(mes_q, anio_q);
        lim_new = lim;
        key_up  = (key_code == KEY_UP);
        key_dn  = (key_code == KEY_DOWN);

        if (f2) begin
            // Edit mode swallows inc_dia entirely.
            if (en_codigo && (key_up || key_dn)) begin
                case (posicion)
                    P'(POS_DIA): begin
                        if (key_up) dia_d = (dia_q >= lim) ? 5'd1 : dia_q + 5'd1;
                        else        dia_d = (dia_q <= 5'd1) ? lim : dia_q - 5'd1;
                    end
                    P'(POS_MES): begin
                        if (key_up) mes_d = (mes_q >= 4'd12) ? 4'd1 : mes_q + 4'd1;
                        else        mes_d = (mes_q <= 4'd1) ? 4'd12 : mes_q - 4'd1;
                    end
                    P'(POS_ANIO): begin
                        if (key_up) anio_d = (anio_q >= AnioMax) ? 7'd0 : anio_q + 7'd1;
                        else        anio_d = (anio_q == 7'd0) ? AnioMax : anio_q - 7'd1;
                    end
                    default: ;
                endcase
            end
            lim_new = dias_mes(mes_d, anio_d);
            if (dia_d > lim_new) dia_d = lim_new;
        end else if (inc_dia) begin
            if (dia_q < lim) begin
                dia_d = dia_q + 5'd1;
            end else begin
                dia_d = 5'd1;
                if (mes_q >= 4'd12) begin
                    mes_d = 4'd1;
                    if (anio_q >= AnioMax) begin
                        anio_d  = 7'd0;
                        carry_d = 1'b1;
                    end else begin
                        anio_d = anio_q + 7'd1;
                    end
                end else begin
                    mes_d = mes_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dia_q   <= 5'd1;
            mes_q   <= 4'd1;
            anio_q  <= 7'd0;
            carry_q <= 1'b0;
        end else begin
            dia_q   <= dia_d;
            mes_q   <= mes_d;
            anio_q  <= anio_d;
            carry_q <= carry_d;
        end
    end

    bin2bcd_99 u_bcd_dia (
        .bin (7'(dia_q)),
        .bcd (bcd_dia)
    );

    bin2bcd_99 u_bcd_mes (
        .bin (7'(mes_q)),
        .bcd (bcd_mes)
    );

    bin2bcd_99 u_bcd_anio (
        .bin (anio_q),
        .bcd (bcd_anio)
    );

    assign dato_dia   = N'(bcd_dia);
    assign dato_mes   = N'(bcd_mes);
    assign dato_anio  = N'(bcd_anio);
    assign carry_anio = carry_q;

endmodule

// File: tb/tb_cont_fecha.sv
// Directed bench for cont_fecha: rollover, leap years, clamp, edit priority, reset.
module tb_cont_fecha;

    localparam logic [7:0] UP = 8'h75;
    localparam logic [7:0] DN = 8'h72;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] posicion = 2'd3;
    logic       f2 = 1'b0;
    logic       en_codigo = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       inc_dia = 1'b0;
    logic [7:0] dato_dia, dato_mes, dato_anio;
    logic       carry_anio;

    int errors = 0;
    int checks = 0;

    wire [23:0] fecha = {dato_dia, dato_mes, dato_anio};

    always #5 clk = ~clk;

    cont_fecha dut (
        .clk        (clk),
        .rst        (rst),
        .posicion   (posicion),
        .f2         (f2),
        .en_codigo  (en_codigo),
        .key_code   (key_code),
        .inc_dia    (inc_dia),
        .dato_dia   (dato_dia),
        .dato_mes   (dato_mes),
        .dato_anio  (dato_anio),
        .carry_anio (carry_anio)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [1:0] pos, input logic [7:0] code);
        f2        = 1'b1;
        posicion  = pos;
        key_code  = code;
        en_codigo = 1'b1;
        tick();
        en_codigo = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; f2 = 1'b0; en_codigo = 1'b0; inc_dia = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic set_date(input int d, input int m, input int y);
        do_reset();
        if (y > 50) repeat (100 - y) key(2'd2, DN);
        else        repeat (y) key(2'd2, UP);
        repeat (m - 1) key(2'd1, UP);
        repeat (d - 1) key(2'd0, UP);
        f2 = 1'b0;
        posicion = 2'd3;
    endtask

    task automatic pulse_inc();
        inc_dia = 1'b1;
        tick();
        inc_dia = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (fecha !== 24'h010100) begin
            errors++; $display("FAIL reset_date got %h want 010100", fecha);
        end
        checks++;
        if (carry_anio !== 1'b0) begin
            errors++; $display("FAIL reset_carry got %b want 0", carry_anio);
        end
    endtask

    task automatic test_year_wrap();
        set_date(31, 12, 99);
        checks++;
        if (fecha !== 24'h311299) begin
            errors++; $display("FAIL preset_311299 got %h want 311299", fecha);
        end
        pulse_inc();
        checks++;
        if (fecha !== 24'h010100) begin
            errors++; $display("FAIL year_wrap_date got %h want 010100", fecha);
        end
        checks++;
        if (carry_anio !== 1'b1) begin
            errors++; $display("FAIL year_wrap_carry_hi got %b want 1", carry_anio);
        end
        tick();
        checks++;
        if (carry_anio !== 1'b0) begin
            errors++; $display("FAIL year_wrap_carry_lo got %b want 0", carry_anio);
        end
    endtask

    task automatic test_leap();
        set_date(28, 2, 4);
        pulse_inc();
        checks++;
        if (fecha !== 24'h290204) begin
            errors++; $display("FAIL leap_29feb got %h want 290204", fecha);
        end
        pulse_inc();
        checks++;
        if (fecha !== 24'h010304) begin
            errors++; $display("FAIL leap_to_mar got %h want 010304", fecha);
        end
        set_date(28, 2, 5);
        pulse_inc();
        checks++;
        if (fecha !== 24'h010305) begin
            errors++; $display("FAIL nonleap_to_mar got %h want 010305", fecha);
        end
        set_date(1, 2, 4);
        key(2'd0, DN);
        checks++;
        if (fecha !== 24'h290204) begin
            errors++; $display("FAIL day_down_wrap got %h want 290204", fecha);
        end
    endtask

    task automatic test_clamp();
        set_date(31, 3, 5);
        key(2'd1, DN);
        checks++;
        if (fecha !== 24'h280205) begin
            errors++; $display("FAIL clamp_month got %h want 280205", fecha);
        end
        key(2'd2, DN);
        checks++;
        if (fecha !== 24'h280204) begin
            errors++; $display("FAIL year_down_keep got %h want 280204", fecha);
        end
        set_date(29, 2, 4);
        key(2'd2, UP);
        checks++;
        if (fecha !== 24'h280205) begin
            errors++; $display("FAIL clamp_year got %h want 280205", fecha);
        end
    endtask

    task automatic test_edit_priority();
        set_date(5, 1, 0);
        key(2'd1, DN);
        checks++;
        if (fecha !== 24'h051200) begin
            errors++; $display("FAIL month_down_wrap got %h want 051200", fecha);
        end
        inc_dia = 1'b1;
        key(2'd0, UP);
        inc_dia = 1'b0;
        checks++;
        if (fecha !== 24'h061200) begin
            errors++; $display("FAIL edit_over_inc got %h want 061200", fecha);
        end
        pulse_inc();
        checks++;
        if (fecha !== 24'h061200) begin
            errors++; $display("FAIL inc_in_edit got %h want 061200", fecha);
        end
        key(2'd0, 8'h6B);
        key(2'd3, UP);
        checks++;
        if (fecha !== 24'h061200) begin
            errors++; $display("FAIL ignored_keys got %h want 061200", fecha);
        end
        f2 = 1'b0;
        key_code = UP;
        posicion = 2'd0;
        en_codigo = 1'b1;
        f2 = 1'b0;
        @(posedge clk);
        #1;
        en_codigo = 1'b0;
        checks++;
        if (fecha !== 24'h061200) begin
            errors++; $display("FAIL key_without_f2 got %h want 061200", fecha);
        end
    endtask

    task automatic test_back_to_back();
        set_date(30, 1, 0);
        inc_dia = 1'b1;
        tick();
        checks++;
        if (fecha !== 24'h310100) begin
            errors++; $display("FAIL b2b_first got %h want 310100", fecha);
        end
        tick();
        inc_dia = 1'b0;
        checks++;
        if (fecha !== 24'h010200) begin
            errors++; $display("FAIL b2b_second got %h want 010200", fecha);
        end
        tick();
        checks++;
        if (fecha !== 24'h010200) begin
            errors++; $display("FAIL b2b_hold got %h want 010200", fecha);
        end
    endtask

    task automatic test_reset_mid_edit();
        set_date(15, 6, 10);
        checks++;
        if (fecha !== 24'h150610) begin
            errors++; $display("FAIL preset_150610 got %h want 150610", fecha);
        end
        f2 = 1'b1; posicion = 2'd0; key_code = UP; en_codigo = 1'b1; rst = 1'b0;
        tick();
        checks++;
        if (fecha !== 24'h010100) begin
            errors++; $display("FAIL reset_mid_edit got %h want 010100", fecha);
        end
        rst = 1'b1; en_codigo = 1'b0;
        tick();
        checks++;
        if (fecha !== 24'h010100) begin
            errors++; $display("FAIL reset_after_edit got %h want 010100", fecha);
        end
        f2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_year_wrap();
        test_leap();
        test_clamp();
        test_edit_priority();
        test_back_to_back();
        test_reset_mid_edit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
